// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one single-port block RAM between the CPU fetch and data
//           ports, one outstanding issue/wait/ack transaction at a time.
//           Define ARB_RR_EN for round-robin tie-breaking (default: data wins).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ACCESS   = 2'd1;
  localparam logic [1:0] c_RESP     = 2'd2;
  localparam logic [1:0] c_LAT_INIT = 2'(RAM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        lat_cnt_q;
  logic              sel_data_q;
  logic              we_q;
  logic              ram_wea_q;
  logic [ADDR_W-1:0] ram_addra_q;
  logic [DATA_W-1:0] ram_dina_q;
  logic              w_issue;
  logic              w_grant_data;
  logic              w_unused_addr;

  assign w_issue = i_req | d_req;

  // Byte-lane and above-range address bits are deliberately discarded.
  assign w_unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                           d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef ARB_RR_EN
  logic rr_last_q;  // 1 = last grant went to the data port

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b0;
    end else if (state_q == c_IDLE && w_issue) begin
      rr_last_q <= w_grant_data;
    end
  end

  assign w_grant_data = d_req & (~i_req | ~rr_last_q);
`else
  assign w_grant_data = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:   if (w_issue) state_d = c_ACCESS;
      c_ACCESS: if (lat_cnt_q == 2'd0) state_d = c_RESP;
      c_RESP:   state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  // Write strobe is a single-cycle pulse: cleared on every edge unless re-issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q   <= 2'd0;
      sel_data_q  <= 1'b0;
      we_q        <= 1'b0;
      ram_wea_q   <= 1'b0;
      ram_addra_q <= '0;
      ram_dina_q  <= '0;
    end else begin
      ram_wea_q <= 1'b0;
      case (state_q)
        c_IDLE: begin
          if (w_issue) begin
            sel_data_q  <= w_grant_data;
            we_q        <= w_grant_data & d_we;
            ram_wea_q   <= w_grant_data & d_we;
            ram_addra_q <= w_grant_data ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
            lat_cnt_q   <= c_LAT_INIT;
            if (w_grant_data) ram_dina_q <= d_wdata;
          end
        end
        c_ACCESS: begin
          if (lat_cnt_q != 2'd0) lat_cnt_q <= lat_cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != c_IDLE);
    i_ack   = (state_q == c_RESP) & ~sel_data_q;
    d_ack   = (state_q == c_RESP) & sel_data_q;
    i_rdata = i_ack ? ram_douta : '0;
    d_rdata = (d_ack & ~we_q) ? ram_douta : '0;
  end

  assign ram_wea   = ram_wea_q;
  assign ram_addra = ram_addra_q;
  assign ram_dina  = ram_dina_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Scoreboard bench for mem_port_arbiter with behavioural block RAMs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, busy, ram_wea;
  logic [31:0] i_rdata, d_rdata, ram_dina, ram_douta;
  logic [10:0] ram_addra;

  logic        i_req2;
  logic [31:0] i_addr2;
  logic        i_ack2, d_ack2, busy2, ram_wea2;
  logic [31:0] i_rdata2, d_rdata2, ram_dina2, ram_douta2;
  logic [10:0] ram_addra2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RAM_LAT(2)) dut_lat2 (
    .clk(clk), .rst(rst),
    .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2), .i_rdata(i_rdata2),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(d_ack2), .d_rdata(d_rdata2), .busy(busy2),
    .ram_wea(ram_wea2), .ram_addra(ram_addra2), .ram_dina(ram_dina2), .ram_douta(ram_douta2)
  );

  // Behavioural RAMs: latency 1 (main) and latency 2 (second instance).
  logic [31:0] mem  [0:2047];
  logic [31:0] mem2 [0:2047];
  logic [31:0] pipe2_a, pipe2_b;
  bit          mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 2048; i++) begin
        mem[i]  = 32'h0;
        mem2[i] = 32'h0;
      end
      mem[1]  = 32'h1111_0001;
      mem[2]  = 32'hA5A5_0002;
      mem[4]  = 32'h4444_0004;
      mem2[1] = 32'h1111_0001;
      mem_loaded = 1'b1;
    end
    ram_douta <= mem[ram_addra];
    if (ram_wea) mem[ram_addra] = ram_dina;
    pipe2_a <= mem2[ram_addra2];
    pipe2_b <= pipe2_a;
  end
  assign ram_douta2 = pipe2_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          data;
    logic [31:0] rdata;
    int          at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per acknowledge, independent of stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (!i_ack) check("i_rdata_zero_without_ack", i_rdata, 32'h0);
      if (!d_ack) check("d_rdata_zero_without_ack", d_rdata, 32'h0);
      if (i_ack && d_ack) begin
        n_checks++;
        n_fail++;
        $display("FAIL dual_ack: got i_ack=1 d_ack=1 expected at most one (cycle %0d)", cyc);
      end else if (i_ack || d_ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none (cycle %0d)",
                   i_ack, d_ack, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("ack_port_is_data", 32'(d_ack), 32'(mon_e.data));
          check("ack_cycle", 32'(cyc), 32'(mon_e.at));
          check("ack_rdata", d_ack ? d_rdata : i_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit data, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic [31:0] exp_wa, input bit hold);
    int n;
    n = cyc;
    if (data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    sb.push_back('{data, exp_rd, n + 2});
    step();
    check("ram_addra_issue", 32'(ram_addra), exp_wa);
    check("ram_wea_first_access", 32'(ram_wea), 32'(data & we));
    check("busy_access", 32'(busy), 32'h1);
    if (data && we) check("ram_dina_write", ram_dina, wdata);
    if (!hold) begin
      i_req = 1'b0; d_req = 1'b0;
    end
    step();
    check("ram_wea_cleared", 32'(ram_wea), 32'h0);
    check("busy_resp", 32'(busy), 32'h1);
    step();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check("busy_back_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int n;
    int got;
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    i_req2 = 1'b0; i_addr2 = 32'h0;
    repeat (3) step();
    check("rst_ram_wea", 32'(ram_wea), 32'h0);
    check("rst_ram_addra", 32'(ram_addra), 32'h0);
    check("rst_ram_dina", ram_dina, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    step();

    issue(1'b0, 1'b0, 32'h8, 32'h0, 32'hA5A5_0002, 32'd2, 1'b1);
    issue(1'b1, 1'b1, 32'h0, 32'h1234_5678, 32'h0, 32'd0, 1'b1);
    check("mem0_after_write", mem[0], 32'h1234_5678);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 32'd0, 1'b1);

    // Tie, each requester drops after its own ack: data first, fetch three cycles later.
    n = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    i_req = 1'b1; i_addr = 32'h4;
    sb.push_back('{1'b1, 32'hA5A5_0002, n + 2});
    sb.push_back('{1'b0, 32'h1111_0001, n + 5});
    step();
    check("tie_addra_data", 32'(ram_addra), 32'd2);
    step();
    step();
    d_req = 1'b0;
    step();
    check("tie_addra_fetch", 32'(ram_addra), 32'd1);
    step();
    step();
    i_req = 1'b0;

    // Both held for four back-to-back transactions.
    n = cyc;
    d_req = 1'b1; i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      if (k % 2 == 0) sb.push_back('{1'b1, 32'hA5A5_0002, n + 2 + 3 * k});
      else            sb.push_back('{1'b0, 32'h1111_0001, n + 2 + 3 * k});
`else
      sb.push_back('{1'b1, 32'hA5A5_0002, n + 2 + 3 * k});
`endif
    end
    repeat (12) step();
    d_req = 1'b0; i_req = 1'b0;
    step();
    check("busy_after_ties", 32'(busy), 32'h0);

    // Reset on the edge that would have issued a write: nothing happens.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check("preissue_rst_wea", 32'(ram_wea), 32'h0);
    check("preissue_rst_busy", 32'(busy), 32'h0);
    step();
    check("preissue_rst_wea_later", 32'(ram_wea), 32'h0);
    check("mem4_unchanged", mem[4], 32'h4444_0004);

    // Reset during ACCESS aborts a fetch: no acknowledge follows.
    i_req = 1'b1; i_addr = 32'h8;
    step();
    i_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    step();

    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h4444_0004, 32'd4, 1'b1);
    issue(1'b1, 1'b0, 32'h0000_2004, 32'h0, 32'h1111_0001, 32'd1, 1'b1);
    issue(1'b0, 1'b0, 32'hFFFF_E00B, 32'h0, 32'hA5A5_0002, 32'd2, 1'b0);

    // Two-cycle RAM latency: address held two cycles, ack one cycle later.
    n = cyc;
    i_req2 = 1'b1; i_addr2 = 32'h4;
    step();
    check("lat2_addra_first", 32'(ram_addra2), 32'd1);
    step();
    check("lat2_addra_second", 32'(ram_addra2), 32'd1);
    check("lat2_wea", 32'(ram_wea2), 32'h0);
    got = -1;
    for (int k = 0; k < 8 && got < 0; k++) begin
      if (i_ack2) got = cyc;
      else step();
    end
    check("lat2_ack_cycle", 32'(got), 32'(n + 3));
    check("lat2_rdata", i_rdata2, 32'h1111_0001);
    check("lat2_no_d_ack", 32'({d_ack2, |d_rdata2, |ram_dina2}), 32'h0);
    step();
    i_req2 = 1'b0;
    check("lat2_busy_idle", 32'(busy2), 32'h0);

    repeat (4) step();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected $finish before 200000ns");
    $fatal(1);
  end

endmodule

`default_nettype wire
